// File: rtl/int_muldiv_pkg.sv
// Shared op codes, state encoding and operand-signedness helpers for the
// iterative RV32M multiply/divide unit.
package int_muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   // MUL keeps both operands unsigned: the low product word is sign-agnostic.
   function automatic logic op_signed_a(input mdu_op_e o);
      return o inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_signed_b(input mdu_op_e o);
      return o inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/int_muldiv_special.sv
// Detects divide-by-zero and signed-divide overflow, which bypass the
// iterative datapath, and supplies the architecturally defined result.
module int_muldiv_special
   import int_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  mdu_op_e         op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            special_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic b_zero;
   logic ovf;

   assign b_zero = (b_i == '0);
   assign ovf    = (a_i == MIN_NEG) && (b_i == '1);

   always_comb begin
      special_o = 1'b0;
      result_o  = '0;
      unique case (op_i)
         OP_DIV: begin
            if (b_zero) begin
               special_o = 1'b1;
               result_o  = '1;
            end else if (ovf) begin
               special_o = 1'b1;
               result_o  = MIN_NEG;
            end
         end
         OP_DIVU: begin
            if (b_zero) begin
               special_o = 1'b1;
               result_o  = '1;
            end
         end
         OP_REM: begin
            if (b_zero) begin
               special_o = 1'b1;
               result_o  = a_i;
            end else if (ovf) begin
               special_o = 1'b1;
               result_o  = '0;
            end
         end
         OP_REMU: begin
            if (b_zero) begin
               special_o = 1'b1;
               result_o  = a_i;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/int_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on magnitudes, with sign fix-up in a final cycle.
module int_muldiv
   import int_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] y
);

   localparam int               CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   mdu_state_e        state_q, state_d;
   mdu_op_e           op_q, op_d, op_in;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sa_q, sa_d, sb_q, sb_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [XLEN-1:0]   y_q, y_d;

   logic              sign_a, sign_b;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic              sp_flag;
   logic [XLEN-1:0]   sp_result;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift, div_trial;
   logic              div_ok;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s;

   function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
      return neg ? -v : v;
   endfunction

   assign op_in  = mdu_op_e'(op);
   assign sign_a = op_signed_a(op_in) & a[XLEN-1];
   assign sign_b = op_signed_b(op_in) & b[XLEN-1];
   assign a_abs  = cond_neg(sign_a, a);
   assign b_abs  = cond_neg(sign_b, b);

   int_muldiv_special #(.XLEN(XLEN)) u_special (
      .op_i      (op_in),
      .a_i       (a),
      .b_i       (b),
      .special_o (sp_flag),
      .result_o  (sp_result)
   );

   // Multiply: hi:lo is the product, lo initially holds the multiplier and drains out the bottom.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);

   // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_trial = div_shift - {1'b0, opb_q};
   assign div_ok    = ~div_trial[XLEN];

   assign prod   = {hi_q, lo_q};
   assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
   assign quo_s  = cond_neg(sa_q ^ sb_q, lo_q);
   assign rem_s  = cond_neg(sa_q, hi_q);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opb_d   = opb_q;
      y_d     = y_q;
      if (kill) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_d  = op_in;
                  sa_d  = sign_a;
                  sb_d  = sign_b;
                  cnt_d = '0;
                  hi_d  = '0;
                  lo_d  = op_in[2] ? a_abs : b_abs;
                  opb_d = op_in[2] ? b_abs : a_abs;
                  if (sp_flag) begin
                     y_d     = sp_result;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (op_q[2]) begin
                  hi_d = div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], div_ok};
               end else begin
                  hi_d = mul_sum[XLEN:1];
                  lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
               end
               if (cnt_q == CNT_LAST) state_d = ST_SIGN;
            end
            ST_SIGN: begin
               unique case (op_q)
                  OP_MUL:                      y_d = prod_s[XLEN-1:0];
                  OP_MULH, OP_MULHSU, OP_MULHU: y_d = prod_s[2*XLEN-1:XLEN];
                  OP_DIV, OP_DIVU:             y_d = quo_s;
                  default:                     y_d = rem_s;
               endcase
               state_d = ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_MUL;
         cnt_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         opb_q   <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opb_q   <= opb_d;
         y_q     <= y_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign y         = y_q;

endmodule

// File: tb/tb_int_muldiv.sv
// Scoreboarded random and directed bench for the iterative multiply/divide unit.
module tb_int_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        kill;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   string       cn_q[$];
   logic [31:0] cg_q[$];
   logic [31:0] ce_q[$];

   int_muldiv #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   always #5 clk = ~clk;

   // Behavioural reference built on 64-bit integer arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
      longint      sx, sz, ux, uz;
      logic [63:0] r;
      sx = longint'($signed(x));
      sz = longint'($signed(z));
      ux = longint'({32'h0, x});
      uz = longint'({32'h0, z});
      r  = '0;
      case (o)
         3'd0: begin r = sx * sz; return r[31:0];  end
         3'd1: begin r = sx * sz; return r[63:32]; end
         3'd2: begin r = sx * uz; return r[63:32]; end
         3'd3: begin r = ux * uz; return r[63:32]; end
         3'd4: begin
            if (z == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return 32'h8000_0000;
            r = sx / sz; return r[31:0];
         end
         3'd5: begin
            if (z == 0) return 32'hFFFF_FFFF;
            r = ux / uz; return r[31:0];
         end
         3'd6: begin
            if (z == 0) return x;
            if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return 32'h0;
            r = sx % sz; return r[31:0];
         end
         default: begin
            if (z == 0) return x;
            r = ux % uz; return r[31:0];
         end
      endcase
   endfunction

   task automatic post(input string nm, input logic [31:0] got, input logic [31:0] exp);
      cn_q.push_back(nm);
      cg_q.push_back(got);
      ce_q.push_back(exp);
   endtask

   // Monitor: sole owner of the counters; drains posted checks and scores results.
   always @(negedge clk) begin
      string       nm;
      logic [31:0] g, e;
      while (cn_q.size() > 0) begin
         nm = cn_q.pop_front();
         g  = cg_q.pop_front();
         e  = ce_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, g, e);
         end
      end
      if (out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL y_unexpected got=%h exp=none", y);
         end else begin
            e = exp_q.pop_front();
            if (y !== e) begin
               failures++;
               $display("FAIL y_result got=%h exp=%h", y, e);
            end
         end
      end
   end

   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z,
                        input logic [31:0] e, input string nm);
      int   n, lat;
      logic busy_rdy, spc;
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin
         post({nm, "_start_timeout"}, 32'd1, 32'd0);
         return;
      end
      op = o; a = x; b = z; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(e);
      spc = (o >= 3'd4) && (z == 0 || ((o == 3'd4 || o == 3'd6) &&
            x == 32'h8000_0000 && z == 32'hFFFF_FFFF));
      lat = 0;
      busy_rdy = 1'b0;
      while (!out_valid && lat < 100) begin
         busy_rdy |= in_ready;
         @(posedge clk); #1;
         lat++;
      end
      busy_rdy |= in_ready;
      post({nm, "_latency"}, 32'(lat), spc ? 32'd0 : 32'd33);
      post({nm, "_busy_ready"}, 32'(busy_rdy), 32'd0);
      @(posedge clk); #1;
      post({nm, "_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      logic [2:0]  ro;
      logic [31:0] rx, rz;
      logic        seen;
      int          sel;

      rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
      op = 3'd0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      post("reset_in_ready", 32'(in_ready), 32'd1);
      post("reset_out_valid", 32'(out_valid), 32'd0);
      post("reset_y", y, 32'd0);
      @(posedge clk); #1;

      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
      do_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu_min");
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
      do_op(3'd5, 32'd7, 32'd2, 32'd3, "divu_7_2");
      do_op(3'd7, 32'd7, 32'd2, 32'd1, "remu_7_2");
      do_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by0");
      do_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_by0");
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");

      for (int i = 0; i < 40; i++) begin
         ro  = 3'($urandom_range(0, 7));
         rx  = $urandom;
         rz  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) rz = 32'h0;
         else if (sel == 1) begin rx = 32'h8000_0000; rz = 32'hFFFF_FFFF; end
         else if (sel == 2) begin rx = $urandom_range(0, 100); rz = $urandom_range(1, 10); end
         else if (sel == 3) rz = -($urandom_range(1, 9));
         do_op(ro, rx, rz, ref_model(ro, rx, rz), $sformatf("rnd%0d_op%0d", i, ro));
      end

      // Backpressure: result held in DONE while the consumer stalls.
      out_ready = 1'b0;
      op = 3'd5; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(32'd142);
      for (int n = 0; n < 100 && !out_valid; n++) begin @(posedge clk); #1; end
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
         @(posedge clk); #1;
         post($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
         post($sformatf("bp_y%0d", i), y, 32'd142);
         post($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      post("bp_ready_after", 32'(in_ready), 32'd1);
      post("bp_valid_after", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // Kill on the 10th CALC cycle discards the op.
      op = 3'd0; a = 32'd12345; b = 32'd678; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      post("kill_in_ready", 32'(in_ready), 32'd1);
      post("kill_out_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
      post("kill_quiet", 32'(seen), 32'd0);

      // Kill coinciding with an offered op: nothing starts.
      op = 3'd4; a = 32'd5; b = 32'd0; in_valid = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; kill = 1'b0;
      post("kill_accept_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (5) begin @(posedge clk); #1; seen |= out_valid; end
      post("kill_accept_quiet", 32'(seen), 32'd0);

      // Asynchronous reset mid-CALC, then a fresh divide.
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_pre_rst");
      op = 3'd0; a = 32'd99; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      post("arst_out_valid", 32'(out_valid), 32'd0);
      post("arst_y", y, 32'd0);
      post("arst_in_ready", 32'(in_ready), 32'd1);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_after_rst");

      post("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
